// File: rtl/booth_multiplier_if.sv
// Operand/result bundle of the Booth multiplier: start strobe, operands, product and status.
interface booth_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   ab;
  logic                 busy;
  logic                 done;

  modport master (output start, a, b, input ab, busy, done);
  modport slave  (input start, a, b, output ab, busy, done);
endinterface

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, signed WIDTH x WIDTH -> 2*WIDTH.
module booth_multiplier #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  booth_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic                   start_q;
  // Set once start has been sampled low after reset, so a start level held
  // across reset release is not mistaken for a fresh rising edge.
  logic                   armed;
  logic signed [WIDTH:0]  m;
  logic [WIDTH:0]         acc;
  logic [WIDTH-1:0]       q;
  logic                   q_1;
  logic [CW-1:0]          count;

  logic                   accept, step, last;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH+1:0]     shifted;
  logic [WIDTH:0]         acc_nxt;
  logic [WIDTH-1:0]       q_nxt;
  logic                   q1_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave IDLE on an accepted start, return after the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decode: acceptance on a start rising edge in IDLE, stepping while RUN.
  always_comb begin
    accept = (state == IDLE) && bus.start && !start_q && armed;
    step   = (state == RUN);
    last   = step && (count == CW'(1));
  end

  // One Booth step: add/subtract M per {Q0,Q_1}, then arithmetic shift of {A,Q,Q_1}.
  always_comb begin
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    shifted = $signed({sum, q, q_1}) >>> 1;
    {acc_nxt, q_nxt, q1_nxt} = shifted;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      armed    <= 1'b0;
      m        <= '0;
      acc      <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      count    <= '0;
      bus.ab   <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      start_q  <= bus.start;
      armed    <= armed | ~bus.start;
      bus.done <= last;
      if (accept) begin
        m        <= {bus.a[WIDTH-1], bus.a};
        acc      <= '0;
        q        <= bus.b;
        q_1      <= 1'b0;
        count    <= CW'(WIDTH);
        bus.busy <= 1'b1;
      end else if (step) begin
        acc   <= acc_nxt;
        q     <= q_nxt;
        q_1   <= q1_nxt;
        count <= count - CW'(1);
        if (last) begin
          bus.ab   <= {acc_nxt[WIDTH-1:0], q_nxt};
          bus.busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against a plain signed-multiply reference.
module tb_booth_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  booth_multiplier_if #(.WIDTH(W)) bus ();
  booth_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[2*W-1:0];
  endfunction

  // Issue a one-cycle start pulse and wait (bounded) for done.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [2*W-1:0] res, output int lat, output int nbusy);
    @(posedge clk); #1;
    bus.a = x; bus.b = y; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.ab;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ab !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset: ab=%h busy=%b done=%b, need ab=0 busy=0 done=0", bus.ab, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_hold_start();
    int holds[2] = '{5, 20};
    for (int h = 0; h < 2; h++) begin
      int ndone = 0, nbusy = 0;
      logic [2*W-1:0] res = '0;
      @(posedge clk); #1;
      bus.a = 8'd2; bus.b = 8'd5; bus.start = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (c == holds[h] - 1) bus.start = 1'b0;
        if (bus.done) begin ndone++; res = bus.ab; end
        if (bus.busy) nbusy++;
      end
      checks++;
      if (res !== 16'h000A) begin errors++; $display("FAIL hold_ab: got %h need 000a", res); end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL hold_done_count: got %0d need 1", ndone); end
      checks++;
      if (nbusy != W) begin errors++; $display("FAIL hold_busy_cycles: got %0d need %0d", nbusy, W); end
    end
  endtask

  task automatic test_signed();
    logic [2*W-1:0] res;
    int lat, nbusy;
    do_op(8'hFD, 8'd17, res, lat, nbusy);
    checks++;
    if (res !== 16'hFFCD) begin errors++; $display("FAIL neg_x_pos: got %h need ffcd", res); end
    checks++;
    if (lat != W) begin errors++; $display("FAIL latency: got %0d need %0d", lat, W); end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b need 0", bus.done); end
    do_op(8'd17, 8'hFD, res, lat, nbusy);
    checks++;
    if (res !== 16'hFFCD) begin errors++; $display("FAIL pos_x_neg: got %h need ffcd", res); end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    logic [W-1:0]   tb[4] = '{8'h80, 8'h80, 8'hFF, 8'hB3};
    logic [2*W-1:0] te[4] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000};
    logic [2*W-1:0] res;
    int lat, nbusy;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], res, lat, nbusy);
      checks++;
      if (res !== te[i])
        begin errors++; $display("FAIL corner%0d: a=%h b=%h got %h need %h", i, ta[i], tb[i], res, te[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    logic [2*W-1:0] res = '0;
    @(posedge clk); #1;
    bus.a = 8'd9; bus.b = 8'hF5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.a = 8'd100; bus.b = 8'd100; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin ndone++; res = bus.ab; end
    end
    checks++;
    if (res !== ref_mul(8'd9, 8'hF5)) begin errors++; $display("FAIL busy_ignore_ab: got %h need %h", res, ref_mul(8'd9, 8'hF5)); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL busy_ignore_done_count: got %0d need 1", ndone); end
  endtask

  task automatic test_reset_mid();
    int nact = 0;
    logic [2*W-1:0] res;
    int lat, nbusy;
    @(posedge clk); #1;
    bus.a = 8'd50; bus.b = 8'd50; bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ab !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ab=%h busy=%b done=%b, need all 0", bus.ab, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) nact++;
    end
    checks++;
    if (nact != 0) begin errors++; $display("FAIL held_start_after_reset: active cycles %0d need 0", nact); end
    bus.start = 1'b0;
    do_op(8'd6, 8'd7, res, lat, nbusy);
    checks++;
    if (res !== 16'h002A) begin errors++; $display("FAIL after_reset_op: got %h need 002a", res); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   x, y;
    logic [2*W-1:0] exp_ab;
    int lat;
    @(posedge clk); #1;
    x = W'($urandom); y = W'($urandom);
    bus.a = x; bus.b = y; bus.start = 1'b1; exp_ab = ref_mul(x, y);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      lat = 0;
      while (!bus.done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat != W) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d need %0d", i, lat, W); end
      checks++;
      if (bus.ab !== exp_ab) begin errors++; $display("FAIL b2b_ab[%0d]: a=%h b=%h got %h need %h", i, x, y, bus.ab, exp_ab); end
      if (i < 999) begin
        // Fresh start edge in the done cycle.
        x = W'($urandom); y = W'($urandom);
        bus.a = x; bus.b = y; bus.start = 1'b1; exp_ab = ref_mul(x, y);
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_start();
    test_signed();
    test_corners();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
